// File: rtl/atari_pkg.sv
// Shared constants and types for the UART debug bridge: command/reply bytes and
// the bridge state encoding.
package atari_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_BURST = 8'h42;
    localparam logic [7:0] REPLY_OK  = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h45;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_COUNT,
        GET_DATA,
        REQ_BUS,
        BUS_WRITE,
        BUS_READ,
        READ_WAIT,
        SEND,
        SEND_WAIT
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_BURST
    } op_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/byte_tx_handshake.sv
// Presents one byte to a UART transmitter using a strobe/busy handshake.
// The strobe rises only while the transmitter is idle and is held until it reports busy.
module byte_tx_handshake (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       send_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       accept_o,
    output logic [7:0] tx_data_o,
    output logic       tx_strobe_o
);

    logic [7:0] tx_data_q;
    logic       tx_strobe_q;

    assign accept_o = send_i && !tx_busy_i && !tx_strobe_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_data_q   <= 8'h00;
            tx_strobe_q <= 1'b0;
        end else if (accept_o) begin
            tx_data_q   <= byte_i;
            tx_strobe_q <= 1'b1;
        end else if (tx_strobe_q && tx_busy_i) begin
            tx_strobe_q <= 1'b0;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_strobe_o = tx_strobe_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// Debug initiator: decodes 'W', 'R' and 'B' commands from the console UART into
// peripheral register bus accesses and answers with 'K', the read byte, or 'E'.
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 2700000,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_ready_clear,
    output logic [7:0] tx_data,
    output logic       tx_strobe,
    input  logic       tx_busy,
    output logic       bus_request,
    input  logic       bus_grant,
    output logic [7:0] bus_address,
    output logic [7:0] bus_data_out,
    input  logic [7:0] bus_data_in,
    output logic       bus_write_enable,
    output logic       bus_enable,
    output logic [7:0] error_count
);

    import atari_pkg::*;

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_e           state_q;
    op_e              op_q;
    logic [8:0]       remaining_q;
    logic [GAP_W-1:0] gap_q;
    logic [LAT_W-1:0] lat_q;
    logic [7:0]       reply_q;
    logic             rx_clear_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic             bus_en_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       err_q;

    logic receiving;
    logic mid_command;
    logic byte_valid;
    logic timed_out;
    logic tx_accept;

    assign receiving   = (state_q == IDLE) || mid_command;
    assign mid_command = (state_q == GET_ADDR) || (state_q == GET_COUNT) || (state_q == GET_DATA);
    // The cycle after a capture rx_ready may still be high, so it is masked by our own clear.
    assign byte_valid  = receiving && rx_ready && !rx_clear_q;
    assign timed_out   = mid_command && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge raw_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            remaining_q <= '0;
            gap_q       <= '0;
            lat_q       <= '0;
            reply_q     <= 8'h00;
            rx_clear_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_en_q    <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            err_q       <= 8'h00;
        end else begin
            rx_clear_q <= byte_valid;
            bus_we_q   <= 1'b0;
            bus_en_q   <= 1'b0;
            gap_q      <= gap_q + GAP_W'(1);

            case (state_q)
                IDLE: begin
                    gap_q <= '0;
                    if (byte_valid) begin
                        case (rx_data)
                            CMD_WRITE: begin op_q <= OP_WRITE; state_q <= GET_ADDR; end
                            CMD_READ:  begin op_q <= OP_READ;  state_q <= GET_ADDR; end
                            CMD_BURST: begin op_q <= OP_BURST; state_q <= GET_ADDR; end
                            default: begin
                                reply_q <= REPLY_ERR;
                                err_q   <= sat_inc(err_q);
                                state_q <= SEND;
                            end
                        endcase
                    end
                end
                GET_ADDR: begin
                    if (byte_valid) begin
                        gap_q  <= '0;
                        addr_q <= rx_data;
                        case (op_q)
                            OP_BURST: state_q <= GET_COUNT;
                            OP_READ: begin
                                bus_req_q <= 1'b1;
                                state_q   <= REQ_BUS;
                            end
                            default:  state_q <= GET_DATA;
                        endcase
                    end
                end
                GET_COUNT: begin
                    if (byte_valid) begin
                        gap_q       <= '0;
                        remaining_q <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        state_q     <= GET_DATA;
                    end
                end
                GET_DATA: begin
                    if (byte_valid) begin
                        gap_q     <= '0;
                        wdata_q   <= rx_data;
                        bus_req_q <= 1'b1;
                        state_q   <= REQ_BUS;
                    end
                end
                REQ_BUS: begin
                    if (bus_grant) begin
                        if (op_q == OP_READ) begin
                            bus_en_q <= 1'b1;
                            state_q  <= BUS_READ;
                        end else begin
                            bus_we_q <= 1'b1;
                            state_q  <= BUS_WRITE;
                        end
                    end
                end
                BUS_WRITE: begin
                    // The bus is released between burst bytes so the CPU can get in.
                    bus_req_q <= 1'b0;
                    if (op_q == OP_BURST && remaining_q != 9'd1) begin
                        remaining_q <= remaining_q - 9'd1;
                        addr_q      <= addr_q + 8'd1;
                        gap_q       <= '0;
                        state_q     <= GET_DATA;
                    end else begin
                        reply_q <= REPLY_OK;
                        state_q <= SEND;
                    end
                end
                BUS_READ: begin
                    lat_q   <= LAT_W'(READ_LATENCY - 1);
                    state_q <= READ_WAIT;
                end
                READ_WAIT: begin
                    if (lat_q == '0) begin
                        reply_q   <= bus_data_in;
                        bus_req_q <= 1'b0;
                        state_q   <= SEND;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                SEND: begin
                    if (tx_accept) state_q <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    if (!tx_strobe) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // An idle gap abandons the command; completed burst writes stay committed.
            if (timed_out && !byte_valid) begin
                reply_q <= REPLY_ERR;
                err_q   <= sat_inc(err_q);
                state_q <= SEND;
            end
        end
    end

    byte_tx_handshake u_tx (
        .clk_i       (raw_clk),
        .rst_n_i     (reset),
        .send_i      (state_q == SEND),
        .byte_i      (reply_q),
        .tx_busy_i   (tx_busy),
        .accept_o    (tx_accept),
        .tx_data_o   (tx_data),
        .tx_strobe_o (tx_strobe)
    );

    assign rx_ready_clear   = rx_clear_q;
    assign bus_request      = bus_req_q;
    assign bus_address      = addr_q;
    assign bus_data_out     = wdata_q;
    assign bus_write_enable = bus_we_q;
    assign bus_enable       = bus_en_q;
    assign error_count      = err_q;

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Debug initiator that turns a byte stream from the console UART into reads and writes on the 8-bit peripheral register bus.
- Lets a host PC poke and peek video, playfield and sprite registers while the game runs.
- Sits between the uart receive/transmit byte handshakes and the peripheral register bus. It shares that bus with the CPU through a request/grant arbiter.

Parameters:
- TIMEOUT_CYCLES, 2700000: maximum idle gap between bytes of one command (0.1 s at 27 MHz).
- READ_LATENCY, 1: cycles from bus_enable until bus_data_in is valid.

Ports:
- raw_clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_ready  in  1  received byte valid; level, held until cleared.
- rx_ready_clear  out  1  one-cycle pulse acknowledging rx_data.
- tx_data  out  8  byte to transmit.
- tx_strobe  out  1  transmit request.
- tx_busy  in  1  transmitter busy.
- bus_request  out  1  bridge wants the bus.
- bus_grant  in  1  arbiter grants the bus.
- bus_address  out  8  register address.
- bus_data_out  out  8  write data, driven to the peripheral data_in.
- bus_data_in  in  8  read data from the peripheral data_out.
- bus_write_enable  out  1  one-cycle write strobe.
- bus_enable  out  1  one-cycle read strobe.
- error_count  out  8  count of protocol errors, saturating.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Any partial command and its counters are discarded.
  - A transmit in progress is abandoned with tx_strobe=0.
- Byte intake:
  - In any receiving state, when rx_ready=1 and rx_ready_clear=0, capture rx_data and pulse rx_ready_clear for exactly one cycle.
  - No byte is captured in the cycle rx_ready_clear is high.
- Command set:
  - 'W' (0x57) addr data → one bus write, then reply 'K' (0x4B).
  - 'R' (0x52) addr → one bus read, then reply with the read byte.
  - 'B' (0x42) addr N d0..dN-1 → N writes at addr, addr+1, …; N=0 means 256.
    - The address wraps 0xFF→0x00.
    - A single 'K' is sent after the last write.
  - Any other first byte → reply 'E' (0x45) and increment error_count; the count saturates at 255.
- States:
  - IDLE → GET_ADDR on 'W', 'R' or 'B'.
  - GET_ADDR → GET_DATA for 'W'; GET_COUNT for 'B'; REQ_BUS (read) for 'R'.
  - GET_COUNT → GET_DATA.
  - GET_DATA → REQ_BUS (write).
  - REQ_BUS → BUS_WRITE or BUS_READ → READ_WAIT (reads only) → next state:
    - a 'B' command with bytes remaining → GET_DATA;
    - otherwise → SEND → SEND_WAIT → IDLE.
- Bus access:
  - bus_request rises on entry to REQ_BUS.
  - bus_address and bus_data_out are stable from REQ_BUS until bus_request falls.
  - The first cycle with bus_grant=1 performs the access:
    - write: bus_write_enable=1 for one cycle;
    - read: bus_enable=1 for one cycle.
  - Reads capture bus_data_in exactly READ_LATENCY cycles after the bus_enable cycle.
  - bus_request falls the cycle after the strobe (writes) or after the capture (reads).
  - If bus_grant=0, the bridge waits indefinitely in REQ_BUS with no strobe and no timeout.
  - During a 'B' command, bus_request is released between data bytes.
- Transmit:
  - In SEND, once tx_busy=0, load tx_data and set tx_strobe=1.
  - In SEND_WAIT, hold tx_strobe until tx_busy=1 is observed, then clear it.
  - Return to IDLE only after tx_strobe has dropped.
- Timeout:
  - The gap counter runs in GET_ADDR, GET_COUNT and GET_DATA, and reloads on every captured byte.
  - Reaching TIMEOUT_CYCLES abandons the command: no further bus cycle, reply 'E', error_count increments.
  - Writes already completed during a 'B' command stay committed.
- Simultaneous events: a byte that arrives while the bridge is in a bus or send state stays pending on rx_ready and is consumed after the bridge returns to a receiving state.

Decomposition:
- Shared package (atari_pkg) holds:
  - command and reply byte constants 0x57, 0x52, 0x42, 0x4B, 0x45;
  - the state enum.
- One natural sub-module: byte_tx_handshake, the tx_strobe/tx_busy sequencer. It is reusable by other bus-side UART users.

Test Plan:
- Write: rx 0x57, 0x06, 0x3C with bus_grant=1 → one cycle of bus_write_enable with address 0x06 and data 0x3C; tx 0x4B; error_count stays 0.
- Read with a held grant:
  - Stimulus: rx 0x52, 0x43; bus_grant=0 for 20 cycles, then 1; the model returns 0x5A.
  - Required: bus_request stays high for all 20 cycles with no strobe; then bus_enable pulses once; tx 0x5A.
- Burst wrap: rx 0x42, 0xFE, 0x03, 0x11, 0x22, 0x33 → writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33), then a single tx 0x4B.
- Errors:
  - rx 0x99 → tx 0x45, error_count=1.
  - 256 further bad bytes → error_count saturates at 255.
- Timeout: rx 0x57, 0x06, then silence for TIMEOUT_CYCLES (set to 100 in the bench) → no bus strobe, tx 0x45, state back to IDLE; a following valid 'W' command works.
- Reset mid-command: assert reset during SEND_WAIT → next cycle tx_strobe=0, bus_request=0, error_count=0; the next command is processed normally.
